// File: rtl/pong_pkg.sv
// Shared definitions for the pong controller, text overlay and graphics blocks.
// State encoding is fixed so other blocks can decode game_state directly.
package pong_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

endpackage

// File: rtl/pong_bcd_counter.sv
// Two-digit BCD score counter: clears on clr, increments on inc, and holds at 99.
module pong_bcd_counter
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] dig0,
  output logic [BCD_W-1:0] dig1
);

  logic at_max;

  assign at_max = (dig1 == 4'd9) && (dig0 == 4'd9);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      dig0 <= '0;
      dig1 <= '0;
    end else if (inc && !at_max) begin
      if (dig0 == 4'd9) begin
        dig0 <= '0;
        dig1 <= dig1 + 4'd1;
      end else begin
        dig0 <= dig0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: game FSM, ball count, and the post-miss frame timer.
// PONG_CTRL_HISCORE_EN adds a high-score register, loaded when a game ends.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_BALLS    = 3,
  parameter int TIMER_FRAMES = 120
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       btn,
  input  logic             tick,
  input  logic             hit,
  input  logic             miss,
  output logic [BCD_W-1:0] dig0,
  output logic [BCD_W-1:0] dig1,
  output logic [1:0]       ball,
  output logic [1:0]       game_state,
  output logic             graph_still
`ifdef PONG_CTRL_HISCORE_EN
  ,
  output logic [BCD_W-1:0] hi_dig0,
  output logic [BCD_W-1:0] hi_dig1
`endif
);

  localparam logic [1:0] BALLS_INIT = 2'(NUM_BALLS);
  localparam logic [7:0] TIMER_INIT = 8'(TIMER_FRAMES);

  state_t     state, state_nxt;
  logic       btn_q;
  logic [7:0] timer;
  logic [1:0] ball_nxt;
  logic       press, timer_up;
  logic       load_timer, score_clr, score_inc;

  assign press      = (|btn) & ~btn_q;
  assign timer_up   = (timer == 8'd0);
  assign game_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= NEWGAME;
      btn_q       <= 1'b0;
      timer       <= 8'd0;
      ball        <= BALLS_INIT;
      graph_still <= 1'b1;
    end else begin
      state       <= state_nxt;
      btn_q       <= |btn;
      ball        <= ball_nxt;
      graph_still <= (state_nxt != PLAY);
      if (load_timer)
        timer <= TIMER_INIT;
      else if (tick && !timer_up)
        timer <= timer - 8'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    ball_nxt   = ball;
    load_timer = 1'b0;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    case (state)
      NEWGAME: begin
        score_clr = 1'b1;
        ball_nxt  = BALLS_INIT;
        if (press) begin
          state_nxt = PLAY;
          ball_nxt  = BALLS_INIT - 2'd1;
        end
      end
      PLAY: begin
        // a miss wins over a simultaneous hit, so the score stays put
        if (miss) begin
          load_timer = 1'b1;
          if (ball == 2'd0) begin
            state_nxt = OVER;
          end else begin
            state_nxt = NEWBALL;
            ball_nxt  = ball - 2'd1;
          end
        end else if (hit) begin
          score_inc = 1'b1;
        end
      end
      NEWBALL: begin
        if (timer_up && press)
          state_nxt = PLAY;
      end
      OVER: begin
        // clear on the exit edge so NEWGAME already shows 00
        if (timer_up) begin
          state_nxt = NEWGAME;
          score_clr = 1'b1;
          ball_nxt  = BALLS_INIT;
        end
      end
      default: state_nxt = NEWGAME;
    endcase
  end

  pong_bcd_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .dig0  (dig0),
    .dig1  (dig1)
  );

`ifdef PONG_CTRL_HISCORE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_dig0 <= '0;
      hi_dig1 <= '0;
    end else if (state == PLAY && state_nxt == OVER &&
                 {dig1, dig0} > {hi_dig1, hi_dig0}) begin
      hi_dig0 <= dig0;
      hi_dig1 <= dig1;
    end
  end
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: an integer game model queues the expected
// outputs per cycle, a monitor pops and compares them after each clock edge.
module tb_pong_game_ctrl;

  localparam int NB = 3;
  localparam int TF = 120;

  logic       clk = 1'b0;
  logic       reset, tick, hit, miss;
  logic [1:0] btn;
  logic [3:0] dig0, dig1;
  logic [1:0] ball, game_state;
  logic       graph_still;
`ifdef PONG_CTRL_HISCORE_EN
  logic [3:0] hi_dig0, hi_dig1;
`endif

  pong_game_ctrl #(.NUM_BALLS(NB), .TIMER_FRAMES(TF)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .tick        (tick),
    .hit         (hit),
    .miss        (miss),
    .dig0        (dig0),
    .dig1        (dig1),
    .ball        (ball),
    .game_state  (game_state),
    .graph_still (graph_still)
`ifdef PONG_CTRL_HISCORE_EN
    ,
    .hi_dig0     (hi_dig0),
    .hi_dig1     (hi_dig1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] bl;
    logic       gs;
    logic [3:0] h0;
    logic [3:0] h1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // game model: state 0=new game, 1=play, 2=new ball, 3=over; score is 0..99
  int m_state = 0, m_score = 0, m_balls = NB, m_timer = 0, m_hi = 0;
  bit m_prev = 1'b0;

  task automatic model_step(input bit r, input logic [1:0] b, input bit tk, input bit h, input bit ms);
    bit   pr, tu;
    exp_t e;
    if (r) begin
      m_state = 0; m_score = 0; m_balls = NB; m_timer = 0; m_prev = 1'b0; m_hi = 0;
    end else begin
      pr     = (b != 2'b00) && !m_prev;
      m_prev = (b != 2'b00);
      tu     = (m_timer == 0);
      if (tk && m_timer > 0) m_timer = m_timer - 1;
      case (m_state)
        0: begin
          m_score = 0;
          m_balls = NB;
          if (pr) begin m_state = 1; m_balls = NB - 1; end
        end
        1: begin
          if (ms) begin
            m_timer = TF;
            if (m_balls == 0) begin
              m_state = 3;
              if (m_score > m_hi) m_hi = m_score;
            end else begin
              m_state = 2;
              m_balls = m_balls - 1;
            end
          end else if (h && m_score < 99) begin
            m_score = m_score + 1;
          end
        end
        2: if (tu && pr) m_state = 1;
        default: if (tu) begin m_state = 0; m_score = 0; m_balls = NB; end
      endcase
    end
    e.st = 2'(m_state);
    e.d0 = 4'(m_score % 10);
    e.d1 = 4'(m_score / 10);
    e.bl = 2'(m_balls);
    e.gs = (m_state != 1);
    e.h0 = 4'(m_hi % 10);
    e.h1 = 4'(m_hi / 10);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit r, input logic [1:0] b, input bit tk, input bit h, input bit ms);
    reset = r; btn = b; tick = tk; hit = h; miss = ms;
    model_step(r, b, tk, h, ms);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n, input logic [1:0] b);
    repeat (n) step(1'b0, b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_btn();
    step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic play_game(input int n);
    press_btn();
    repeat (n) step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NB; k++) begin
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      ticks(TF, 2'b00);
      if (k < NB - 1) press_btn();
    end
    idle(2);
  endtask

  // monitor: every clock edge the DUT presents a new registered output set
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("game_state", int'(game_state), int'(e.st));
        chk("dig0", int'(dig0), int'(e.d0));
        chk("dig1", int'(dig1), int'(e.d1));
        chk("ball", int'(ball), int'(e.bl));
        chk("graph_still", int'(graph_still), int'(e.gs));
`ifdef PONG_CTRL_HISCORE_EN
        chk("hi_dig0", int'(hi_dig0), int'(e.h0));
        chk("hi_dig1", int'(hi_dig1), int'(e.h1));
`endif
      end
    end
  end

  initial begin
    logic [1:0] rb;
    reset = 1'b1; btn = 2'b00; tick = 1'b0; hit = 1'b0; miss = 1'b0;
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(2);

    press_btn();
    repeat (105) begin
      step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    end

    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    ticks(49, 2'b00);
    step(1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
    ticks(70, 2'b00);
    ticks(3, 2'b00);
    press_btn();

    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    ticks(110, 2'b00);
    ticks(20, 2'b10);
    idle(2);
    press_btn();

    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    ticks(TF, 2'b00);
    idle(3);

    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1);
    play_game(12);
    play_game(7);

    press_btn();
    repeat (5) step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
    idle(3);

    rb = 2'b00;
    repeat (20000) begin
      if ($urandom_range(7) == 0) rb = 2'($urandom_range(3));
      step($urandom_range(1999) == 0, rb, $urandom_range(1) == 1,
           $urandom_range(3) == 0, $urandom_range(39) == 0);
    end

    idle(2);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
